// File: rtl/tmu_decay_arb_pkg.sv
// ---------------------------------------------------------------------------
// tmu_decay_arb_pkg
//   Shared definitions for the TMU decay-pipeline arbiter:
//     - arbiter state encodings (IDLE / GRANT / DRAIN)
//     - source identifiers for the owner / last-owner registers
//     - RGB565 field widths and the 6-bit brightness format
// ---------------------------------------------------------------------------
package tmu_decay_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        TMU_ARB_IDLE  = 2'd0,
        TMU_ARB_GRANT = 2'd1,
        TMU_ARB_DRAIN = 2'd2
    } tmu_arb_state_e;

    // Source identifiers, as held in the owner and last-owner registers
    localparam logic SRC_A = 1'b0;   // texture-mapped pixels
    localparam logic SRC_B = 1'b1;   // feedback / clear pass

    // RGB565 field widths
    localparam int unsigned RGB_R_W = 5;
    localparam int unsigned RGB_G_W = 6;
    localparam int unsigned RGB_B_W = 5;
    localparam int unsigned PIXEL_W = RGB_R_W + RGB_G_W + RGB_B_W;

    // Brightness (decay factor); full value passes the pixel unchanged
    localparam int unsigned BRIGHT_W    = 6;
    localparam logic [5:0]  BRIGHT_FULL = 6'h3f;

endpackage

// File: rtl/tmu_rr_pick2.sv
// ---------------------------------------------------------------------------
// tmu_rr_pick2
//   Combinational 2-way round-robin pick.
//   When both sources request, the one that did not own the pipeline last
//   wins; otherwise the sole requester wins.
//
// Ports
//   req_a    in   1  source A requesting
//   req_b    in   1  source B requesting
//   last     in   1  previous owner (SRC_A / SRC_B)
//   grant_b  out  1  1: B wins, 0: A wins (valid only when any=1)
//   any      out  1  at least one source requesting
// ---------------------------------------------------------------------------
module tmu_rr_pick2
    import tmu_decay_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic grant_b,
    output logic any
);

    always_comb begin
        any     = req_a | req_b;
        // B wins alone, or on contention when A was the last owner
        grant_b = req_b & (~req_a | (last == SRC_A));
    end

endmodule

// File: rtl/tmu_decay_arb.sv
// ---------------------------------------------------------------------------
// tmu_decay_arb
//   Shares the 3-stage TMU decay pipeline between two pixel sources,
//   A (texture-mapped pixels) and B (feedback / clear pass).
//   Ownership is granted per burst. Before the owner changes, the arbiter
//   waits for the decay pipeline to drain so that the downstream FML write
//   stage never sees pixels of A and B interleaved.
//
// Parameters
//   fml_depth  FML address width; pixel addresses are fml_depth-1 bits
//   max_burst  max pixels per grant before forced re-arbitration (>=1)
//
// Ports
//   sys_clk       in   system clock
//   sys_rst_n     in   asynchronous active-low reset
//   busy          out  arbiter not idle, or decay pipeline busy
//   a_stb_i       in   source A pixel valid
//   a_ack_o       out  source A pixel accepted
//   a_pixel       in   source A RGB565 pixel
//   a_dst_addr    in   source A destination address
//   a_brightness  in   source A decay factor (6'h3f = pass-through)
//   b_*                same five ports for source B
//   pipe_stb_o    out  pixel valid towards decay
//   pipe_ack_i    in   decay accept / pipeline advance
//   src_pixel     out  owner's pixel
//   dst_addr      out  owner's address
//   brightness    out  owner's brightness
//   decay_busy    in   decay pipeline holds valid pixels
// ---------------------------------------------------------------------------
module tmu_decay_arb
    import tmu_decay_arb_pkg::*;
#(
    parameter int unsigned fml_depth = 26,
    parameter int unsigned max_burst = 64
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    output logic                   busy,

    input  logic                   a_stb_i,
    output logic                   a_ack_o,
    input  logic [PIXEL_W-1:0]     a_pixel,
    input  logic [fml_depth-2:0]   a_dst_addr,
    input  logic [BRIGHT_W-1:0]    a_brightness,

    input  logic                   b_stb_i,
    output logic                   b_ack_o,
    input  logic [PIXEL_W-1:0]     b_pixel,
    input  logic [fml_depth-2:0]   b_dst_addr,
    input  logic [BRIGHT_W-1:0]    b_brightness,

    output logic                   pipe_stb_o,
    input  logic                   pipe_ack_i,
    output logic [PIXEL_W-1:0]     src_pixel,
    output logic [fml_depth-2:0]   dst_addr,
    output logic [BRIGHT_W-1:0]    brightness,
    input  logic                   decay_busy
);

    // Beat counter width: clog2(max_burst), at least one bit
    localparam int unsigned CntW = (max_burst > 1) ? $clog2(max_burst) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(max_burst - 1);

    tmu_arb_state_e  state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q,  last_d;
    logic [CntW-1:0] count_q, count_d;

    logic owner_stb;
    logic granting;
    logic transfer;
    logic pick_last;
    logic pick_b;
    logic pick_any;

    assign owner_stb = (owner_q == SRC_B) ? b_stb_i : a_stb_i;
    assign granting  = (state_q == TMU_ARB_GRANT);
    assign transfer  = granting & owner_stb & pipe_ack_i;

    // In DRAIN the last-owner register is only being updated this cycle, so
    // a re-grant straight out of DRAIN must already see the current owner as
    // "last" to keep the rotation fair.
    assign pick_last = (state_q == TMU_ARB_DRAIN) ? owner_q : last_q;

    tmu_rr_pick2 u_pick (
        .req_a   (a_stb_i),
        .req_b   (b_stb_i),
        .last    (pick_last),
        .grant_b (pick_b),
        .any     (pick_any)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        count_d = count_q;

        unique case (state_q)
            TMU_ARB_IDLE: begin
                if (pick_any) begin
                    state_d = TMU_ARB_GRANT;
                    owner_d = pick_b ? SRC_B : SRC_A;
                    count_d = '0;
                end
            end

            TMU_ARB_GRANT: begin
                // Dropping stb ends the burst even if it comes back next cycle
                if (!owner_stb) begin
                    state_d = TMU_ARB_DRAIN;
                end else if (transfer) begin
                    if (count_q == CntLast) begin
                        state_d = TMU_ARB_DRAIN;
                    end else begin
                        count_d = count_q + CntW'(1);
                    end
                end
            end

            TMU_ARB_DRAIN: begin
                last_d = owner_q;
                // decay_busy only clears as pipe_ack_i advances the decay stages
                if (!decay_busy) begin
                    if (pick_any) begin
                        state_d = TMU_ARB_GRANT;
                        owner_d = pick_b ? SRC_B : SRC_A;
                        count_d = '0;
                    end else begin
                        state_d = TMU_ARB_IDLE;
                    end
                end
            end

            default: begin
                state_d = TMU_ARB_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers; last=B after reset so A wins the first contention
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= TMU_ARB_IDLE;
            owner_q <= SRC_A;
            last_q  <= SRC_B;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Handshake: combinational, only while granting
    // -----------------------------------------------------------------------
    always_comb begin
        pipe_stb_o = granting & owner_stb;
        a_ack_o    = granting & (owner_q == SRC_A) & pipe_ack_i;
        b_ack_o    = granting & (owner_q == SRC_B) & pipe_ack_i;
        busy       = (state_q != TMU_ARB_IDLE) | decay_busy;
    end

    // -----------------------------------------------------------------------
    // Data mux: follows the owner register, meaningful while pipe_stb_o=1.
    // Brightness travels with each pixel, so an owner change needs no
    // special handling here.
    // -----------------------------------------------------------------------
    always_comb begin
        if (owner_q == SRC_B) begin
            src_pixel  = b_pixel;
            dst_addr   = b_dst_addr;
            brightness = b_brightness;
        end else begin
            src_pixel  = a_pixel;
            dst_addr   = a_dst_addr;
            brightness = a_brightness;
        end
    end

endmodule

// File: tb/tb_tmu_decay_arb.sv
module tb_tmu_decay_arb;

    localparam int unsigned FmlDepth = 26;
    localparam int unsigned MaxBurst = 4;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n;
    logic                busy;
    logic                a_stb_i, a_ack_o;
    logic [15:0]         a_pixel;
    logic [FmlDepth-2:0] a_dst_addr;
    logic [5:0]          a_brightness;
    logic                b_stb_i, b_ack_o;
    logic [15:0]         b_pixel;
    logic [FmlDepth-2:0] b_dst_addr;
    logic [5:0]          b_brightness;
    logic                pipe_stb_o, pipe_ack_i;
    logic [15:0]         src_pixel;
    logic [FmlDepth-2:0] dst_addr;
    logic [5:0]          brightness;
    logic                decay_busy;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    tmu_decay_arb #(
        .fml_depth (FmlDepth),
        .max_burst (MaxBurst)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .busy         (busy),
        .a_stb_i      (a_stb_i),
        .a_ack_o      (a_ack_o),
        .a_pixel      (a_pixel),
        .a_dst_addr   (a_dst_addr),
        .a_brightness (a_brightness),
        .b_stb_i      (b_stb_i),
        .b_ack_o      (b_ack_o),
        .b_pixel      (b_pixel),
        .b_dst_addr   (b_dst_addr),
        .b_brightness (b_brightness),
        .pipe_stb_o   (pipe_stb_o),
        .pipe_ack_i   (pipe_ack_i),
        .src_pixel    (src_pixel),
        .dst_addr     (dst_addr),
        .brightness   (brightness),
        .decay_busy   (decay_busy)
    );

    // ---------------------------------------------------------------------
    // Decay pipeline model: 3 stages, advance on pipe_ack_i,
    // component * (brightness+1) >> 6.
    // ---------------------------------------------------------------------
    function automatic logic [15:0] scale(input logic [15:0] p, input logic [5:0] k);
        logic [11:0] m, r, g, b;
        m = {6'd0, k} + 12'd1;
        r = {7'd0, p[15:11]} * m;
        g = {6'd0, p[10:5]} * m;
        b = {7'd0, p[4:0]} * m;
        return {r[10:6], g[11:6], b[10:6]};
    endfunction

    logic [2:0]  s_v;
    logic [15:0] s_p0, s_p1, s_p2;
    logic [15:0] out_mem [64];
    int          out_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s_v     <= 3'b000;
            s_p0    <= 16'h0;
            s_p1    <= 16'h0;
            s_p2    <= 16'h0;
            out_cnt <= 0;
        end else if (pipe_ack_i) begin
            s_v  <= {s_v[1:0], pipe_stb_o};
            s_p0 <= scale(src_pixel, brightness);
            s_p1 <= s_p0;
            s_p2 <= s_p1;
            if (s_v[2]) begin
                out_mem[out_cnt[5:0]] <= s_p2;
                out_cnt <= out_cnt + 1;
            end
        end
    end

    assign decay_busy = |s_v;

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n  = 1'b0;
        a_stb_i    = 1'b0;
        b_stb_i    = 1'b0;
        pipe_ack_i = 1'b1;
        tick();
        tick();
        sys_rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        a_stb_i = 1'b0;
        b_stb_i = 1'b0;
        pipe_ack_i = 1'b1;
        #1;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%b required 0 after %0d cycles", busy, n);
        end
    endtask

    // ---------------------------------------------------------------------
    // 1. Reset with A requesting, first grant, decay result
    // ---------------------------------------------------------------------
    task automatic test_reset();
        int n;
        sys_rst_n    = 1'b0;
        a_stb_i      = 1'b1;
        a_pixel      = 16'hF800;
        a_brightness = 6'd31;
        a_dst_addr   = 25'h0123456;
        b_stb_i      = 1'b0;
        b_pixel      = 16'h0;
        b_brightness = 6'h0;
        b_dst_addr   = '0;
        pipe_ack_i   = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({a_ack_o, b_ack_o, pipe_stb_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_acks: a_ack/b_ack/stb=%b required 000",
                     {a_ack_o, b_ack_o, pipe_stb_o});
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: busy=%b required 0", busy);
        end
        sys_rst_n = 1'b1;
        #1;
        checks++;
        if (a_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_ack: a_ack=%b required 0", a_ack_o);
        end
        tick();
        checks++;
        if (a_ack_o !== 1'b1 || b_ack_o !== 1'b0 || pipe_stb_o !== 1'b1) begin
            failures++;
            $display("FAIL grant_a_first: a_ack/b_ack/stb=%b required 101",
                     {a_ack_o, b_ack_o, pipe_stb_o});
        end
        checks++;
        if (src_pixel !== 16'hF800 || brightness !== 6'd31 || dst_addr !== 25'h0123456) begin
            failures++;
            $display("FAIL mux_a: pix=%h br=%h addr=%h required F800 1f 0123456",
                     src_pixel, brightness, dst_addr);
        end
        tick();
        a_stb_i = 1'b0;
        n = 0;
        while (out_cnt == 0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (out_cnt !== 1 || out_mem[0] !== 16'h7800) begin
            failures++;
            $display("FAIL decay_out: count=%0d pix=%h required 1 7800", out_cnt, out_mem[0]);
        end
        wait_idle();
    endtask

    // ---------------------------------------------------------------------
    // 2. A streams alone: 4 beats, 4-cycle drain, re-grant
    // ---------------------------------------------------------------------
    task automatic test_burst();
        logic [23:0] obs_a, obs_b;
        a_pixel      = 16'h07E0;
        a_brightness = 6'h3f;
        a_stb_i      = 1'b1;
        pipe_ack_i   = 1'b1;
        #1;
        obs_a[0] = a_ack_o;
        obs_b[0] = b_ack_o;
        for (int c = 1; c < 24; c++) begin
            tick();
            obs_a[c] = a_ack_o;
            obs_b[c] = b_ack_o;
        end
        checks++;
        if (obs_a !== 24'h1E1E1E) begin
            failures++;
            $display("FAIL burst_acks: a_ack pattern=%h required 1e1e1e", obs_a);
        end
        checks++;
        if (obs_b !== 24'h0) begin
            failures++;
            $display("FAIL burst_b_idle: b_ack pattern=%h required 000000", obs_b);
        end
        wait_idle();
    endtask

    // ---------------------------------------------------------------------
    // 3. Both requesting: A x4, drain, B x4, drain, A ...
    // ---------------------------------------------------------------------
    task automatic test_contention();
        logic [23:0] obs_a, obs_b;
        int both;
        do_reset();
        a_pixel      = 16'h1111;
        a_brightness = 6'h3f;
        b_pixel      = 16'h2222;
        b_brightness = 6'h3f;
        a_stb_i      = 1'b1;
        b_stb_i      = 1'b1;
        both         = 0;
        #1;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) tick();
            obs_a[c] = a_ack_o;
            obs_b[c] = b_ack_o;
            if (a_ack_o && b_ack_o) both++;
        end
        checks++;
        if (obs_a !== 24'h1E001E) begin
            failures++;
            $display("FAIL rr_a_acks: pattern=%h required 1e001e", obs_a);
        end
        checks++;
        if (obs_b !== 24'h001E00) begin
            failures++;
            $display("FAIL rr_b_acks: pattern=%h required 001e00", obs_b);
        end
        checks++;
        if (both !== 0) begin
            failures++;
            $display("FAIL rr_exclusive: both-ack cycles=%0d required 0", both);
        end
        wait_idle();
    endtask

    // ---------------------------------------------------------------------
    // 4. pipe_ack_i low mid-burst and during drain
    // ---------------------------------------------------------------------
    task automatic test_stall();
        int bad, n;
        do_reset();
        a_pixel      = 16'h0F0F;
        a_brightness = 6'h3f;
        a_stb_i      = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (a_ack_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_pre: a_ack=%b required 1", a_ack_o);
        end
        tick();
        pipe_ack_i = 1'b0;
        bad = 0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            if (a_ack_o !== 1'b0 || pipe_stb_o !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL stall_grant: bad cycles=%0d required 0", bad);
        end
        tick();
        pipe_ack_i = 1'b1;
        #1;
        checks++;
        if (a_ack_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_beat3: a_ack=%b required 1", a_ack_o);
        end
        tick();
        checks++;
        if (a_ack_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_beat4: a_ack=%b required 1", a_ack_o);
        end
        tick();
        pipe_ack_i = 1'b0;
        #1;
        checks++;
        if ({a_ack_o, pipe_stb_o, busy, decay_busy} !== 4'b0011) begin
            failures++;
            $display("FAIL drain_entered: ack/stb/busy/dbusy=%b required 0011",
                     {a_ack_o, pipe_stb_o, busy, decay_busy});
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            if (a_ack_o !== 1'b0 || decay_busy !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL drain_hold: bad cycles=%0d required 0", bad);
        end
        tick();
        pipe_ack_i = 1'b1;
        #1;
        n = 0;
        while (!a_ack_o && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL drain_release: cycles to re-grant=%0d required 4", n);
        end
        wait_idle();
    endtask

    // ---------------------------------------------------------------------
    // 5. Owner A drops stb after 2 beats; B takes over, pass-through
    // ---------------------------------------------------------------------
    task automatic test_drop_stb();
        int n;
        do_reset();
        a_pixel      = 16'hFFFF;
        a_brightness = 6'h00;
        b_pixel      = 16'h1234;
        b_brightness = 6'h3f;
        b_dst_addr   = 25'h00ABCDE;
        a_stb_i      = 1'b1;
        b_stb_i      = 1'b1;
        tick();
        checks++;
        if (a_ack_o !== 1'b1 || b_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL drop_first: a_ack/b_ack=%b required 10", {a_ack_o, b_ack_o});
        end
        tick();
        tick();
        a_stb_i = 1'b0;
        #1;
        checks++;
        if (pipe_stb_o !== 1'b0 || b_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL drop_no_stb: stb/b_ack=%b required 00", {pipe_stb_o, b_ack_o});
        end
        n = 0;
        while (!b_ack_o && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (b_ack_o !== 1'b1 || a_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL b_granted: a_ack/b_ack=%b required 01", {a_ack_o, b_ack_o});
        end
        checks++;
        if (src_pixel !== 16'h1234 || brightness !== 6'h3f || dst_addr !== 25'h00ABCDE) begin
            failures++;
            $display("FAIL mux_b: pix=%h br=%h addr=%h required 1234 3f 00abcde",
                     src_pixel, brightness, dst_addr);
        end
        tick();
        b_stb_i = 1'b0;
        wait_idle();
        checks++;
        if (out_cnt !== 3) begin
            failures++;
            $display("FAIL drop_count: pixels out=%0d required 3", out_cnt);
        end
        checks++;
        if (out_mem[0] !== 16'h0000 || out_mem[1] !== 16'h0000) begin
            failures++;
            $display("FAIL drop_a_decay: %h %h required 0000 0000", out_mem[0], out_mem[1]);
        end
        checks++;
        if (out_mem[2] !== 16'h1234) begin
            failures++;
            $display("FAIL b_passthrough: %h required 1234", out_mem[2]);
        end
    endtask

    // ---------------------------------------------------------------------
    // 6. Reset while B owns the pipeline; A has priority afterwards
    // ---------------------------------------------------------------------
    task automatic test_async_reset();
        int n;
        do_reset();
        a_stb_i = 1'b1;
        b_stb_i = 1'b1;
        #1;
        n = 0;
        while (!b_ack_o && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (b_ack_o !== 1'b1) begin
            failures++;
            $display("FAIL b_before_rst: b_ack=%b required 1", b_ack_o);
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ack_o, b_ack_o, pipe_stb_o} !== 3'b000) begin
            failures++;
            $display("FAIL async_drop: a_ack/b_ack/stb=%b required 000",
                     {a_ack_o, b_ack_o, pipe_stb_o});
        end
        tick();
        sys_rst_n = 1'b1;
        #1;
        checks++;
        if (a_ack_o !== 1'b0 || b_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_idle: a_ack/b_ack=%b required 00", {a_ack_o, b_ack_o});
        end
        tick();
        checks++;
        if (a_ack_o !== 1'b1 || b_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL a_priority_after_rst: a_ack/b_ack=%b required 10",
                     {a_ack_o, b_ack_o});
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_burst();
        test_contention();
        test_stall();
        test_drop_stb();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
